// File: rtl/load_store_unit_if.sv
// Request, response and memory-side bus of the load/store unit.
// The unit connects through the slave modport. The CPU and memory side connects through the master modport.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_abort;

    logic [31:0] mem_address;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output rsp_ready, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_abort,
        input  mem_address, mem_write_en, mem_write_data
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  rsp_ready, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_abort,
        output mem_address, mem_write_en, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store bus initiator: read-modify-write sub-word stores, extended sub-word loads, range/size aborts.
// Optional macro MISALIGN_ABORT_EN also aborts unaligned halfword/word requests.
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input logic          clk,
    input logic          reset,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;
    localparam logic [1:0]  SIZE_BAD  = 2'b11;
    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        abort_q, abort_d;

    logic        misaligned;
    logic        bad_req;
    logic [31:0] store_data;
    logic [31:0] load_data;

`ifdef MISALIGN_ABORT_EN
    assign misaligned = ((bus.req_size == SIZE_HALF) && bus.req_addr[0]) ||
                        ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign bad_req = (bus.req_size == SIZE_BAD) || (bus.req_addr > LAST_ADDR) || misaligned;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    sgn_d   = bus.req_signed;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    word_d  = '0;
                    abort_d = bad_req;
                    if (bad_req)
                        state_d = RESP;
                    else if (!bus.req_write || (bus.req_size != SIZE_WORD))
                        state_d = READ;
                    else
                        state_d = WRITE;
                end
            end
            READ: begin
                word_d  = bus.mem_read_data;
                state_d = write_q ? WRITE : RESP;
            end
            WRITE:   state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sub-word stores splice the new lanes into the word fetched during READ.
    always_comb begin
        case (size_q)
            SIZE_BYTE: store_data = {word_q[31:8], wdata_q[7:0]};
            SIZE_HALF: store_data = {word_q[31:16], wdata_q[15:0]};
            default:   store_data = wdata_q;
        endcase
    end

    always_comb begin
        case (size_q)
            SIZE_BYTE: load_data = {{24{sgn_q & word_q[7]}}, word_q[7:0]};
            SIZE_HALF: load_data = {{16{sgn_q & word_q[15]}}, word_q[15:0]};
            default:   load_data = word_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            abort_q <= abort_d;
        end
    end

    // Outputs are gated by reset so a store caught in WRITE never commits during the reset cycle.
    assign bus.req_ready      = !reset && (state_q == IDLE);
    assign bus.rsp_valid      = !reset && (state_q == RESP);
    assign bus.rsp_abort      = !reset && (state_q == RESP) && abort_q;
    assign bus.rsp_rdata      = (!reset && (state_q == RESP) && !write_q && !abort_q) ? load_data : '0;
    assign bus.mem_address    = (!reset && ((state_q == READ) || (state_q == WRITE))) ? addr_q : '0;
    assign bus.mem_write_en   = !reset && (state_q == WRITE);
    assign bus.mem_write_data = (!reset && (state_q == WRITE)) ? store_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of requests plus reset and back-pressure sequences.
// Expectations follow MISALIGN_ABORT_EN when it is defined.
module tb_load_store_unit;

    logic clk;
    logic reset;
    logic mem_init;
    int   checks;
    int   failures;
    int   wr_pulses;
    logic [7:0] mem [0:1023];
    logic [9:0] rd_idx;
    logic [9:0] wr_idx;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd_idx = bus.mem_address[9:0];
    assign wr_idx = bus.mem_address[9:0];

    always_comb begin
        bus.mem_read_data = '0;
        if (bus.mem_address <= 32'd1020)
            bus.mem_read_data = {mem[rd_idx + 10'd3], mem[rd_idx + 10'd2], mem[rd_idx + 10'd1], mem[rd_idx]};
    end

    // Memory model: byte i starts as i[7:0]; a write stores four lanes at the presented address.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
        end else if (bus.mem_write_en) begin
            wr_pulses <= wr_pulses + 1;
            if (bus.mem_address <= 32'd1020) begin
                mem[wr_idx]         <= bus.mem_write_data[7:0];
                mem[wr_idx + 10'd1] <= bus.mem_write_data[15:8];
                mem[wr_idx + 10'd2] <= bus.mem_write_data[23:16];
                mem[wr_idx + 10'd3] <= bus.mem_write_data[31:24];
            end
        end
    end

    typedef struct {
        logic        w;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_abort;
        int          exp_lat;
        int          exp_writes;
    } vec_t;

    vec_t vectors [17];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic startRequest(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd);
        int guard;
        guard = 0;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int lat;
        int base;
        logic [31:0] rdata;
        logic abort;
        base = wr_pulses;
        startRequest(v.w, v.size, v.sgn, v.addr, v.wdata);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = bus.rsp_rdata;
        abort = bus.rsp_abort;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
        checkOutput($sformatf("v%0d_abort", idx), 32'(abort), 32'(v.exp_abort));
        checkOutput($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        checkOutput($sformatf("v%0d_write_pulses", idx), 32'(wr_pulses - base), 32'(v.exp_writes));
        checkOutput($sformatf("v%0d_idle_ready", idx), 32'(bus.req_ready), 32'd1);
        checkOutput($sformatf("v%0d_idle_valid", idx), 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int guard;
        int base;
        checks     = 0;
        failures   = 0;
        wr_pulses  = 0;
        mem_init   = 1'b1;
        reset      = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;

        //                w     size   sgn   addr           wdata          rdata          abort lat wr
        vectors[0]  = '{1'b1, 2'b10, 1'b0, 32'h40,       32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
        vectors[1]  = '{1'b0, 2'b10, 1'b0, 32'h40,       32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        vectors[2]  = '{1'b1, 2'b10, 1'b0, 32'h40,       32'h11223344, 32'h0,        1'b0, 2, 1};
        vectors[3]  = '{1'b1, 2'b00, 1'b0, 32'h41,       32'h123456AB, 32'h0,        1'b0, 3, 1};
        vectors[4]  = '{1'b0, 2'b10, 1'b0, 32'h40,       32'h0,        32'h1122AB44, 1'b0, 2, 0};
        vectors[5]  = '{1'b0, 2'b00, 1'b1, 32'h41,       32'h0,        32'hFFFFFFAB, 1'b0, 2, 0};
        vectors[6]  = '{1'b0, 2'b00, 1'b0, 32'h41,       32'h0,        32'h000000AB, 1'b0, 2, 0};
        vectors[7]  = '{1'b0, 2'b01, 1'b1, 32'h42,       32'h0,        32'h00001122, 1'b0, 2, 0};
        vectors[8]  = '{1'b1, 2'b01, 1'b0, 32'h44,       32'h77779988, 32'h0,        1'b0, 3, 1};
        vectors[9]  = '{1'b0, 2'b01, 1'b1, 32'h44,       32'h0,        32'hFFFF9988, 1'b0, 2, 0};
        vectors[10] = '{1'b0, 2'b01, 1'b0, 32'h44,       32'h0,        32'h00009988, 1'b0, 2, 0};
        vectors[11] = '{1'b0, 2'b10, 1'b0, 32'h3FC,      32'h0,        32'hFFFEFDFC, 1'b0, 2, 0};
        vectors[12] = '{1'b0, 2'b10, 1'b0, 32'h3FE,      32'h0,        32'h0,        1'b1, 1, 0};
        vectors[13] = '{1'b1, 2'b11, 1'b0, 32'h0,        32'hCAFEF00D, 32'h0,        1'b1, 1, 0};
        vectors[14] = '{1'b0, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1, 0};
`ifdef MISALIGN_ABORT_EN
        vectors[15] = '{1'b0, 2'b10, 1'b0, 32'h42,       32'h0,        32'h0,        1'b1, 1, 0};
`else
        vectors[15] = '{1'b0, 2'b10, 1'b0, 32'h42,       32'h0,        32'h99881122, 1'b0, 2, 0};
`endif
        vectors[16] = '{1'b0, 2'b10, 1'b1, 32'h40,       32'h0,        32'h1122AB44, 1'b0, 2, 0};

        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_mem_we", 32'(bus.mem_write_en), 32'd0);
        checkOutput("reset_mem_addr", bus.mem_address, 32'd0);
        checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 17; i++) applyStimulus(vectors[i], i);

        // Back-pressure: response held while rsp_ready stays low.
        startRequest(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        guard = 1;
        while (!bus.rsp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("hold_latency", 32'(guard), 32'd2);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("hold%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
            checkOutput($sformatf("hold%0d_rdata", i), bus.rsp_rdata, 32'h1122AB44);
            checkOutput($sformatf("hold%0d_req_ready", i), 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        checkOutput("hold3_valid", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput("hold_release_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("hold_release_ready", 32'(bus.req_ready), 32'd1);

        // Reset while a byte store is in READ.
        base = wr_pulses;
        startRequest(1'b1, 2'b00, 1'b0, 32'h50, 32'h000000CC);
        checkOutput("rstA_read_addr", bus.mem_address, 32'h50);
        checkOutput("rstA_read_we", 32'(bus.mem_write_en), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rstA_we", 32'(bus.mem_write_en), 32'd0);
        checkOutput("rstA_addr", bus.mem_address, 32'd0);
        checkOutput("rstA_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rstA_idle_ready", 32'(bus.req_ready), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("rstA_no_write", 32'(wr_pulses - base), 32'd0);
        checkOutput("rstA_mem50", 32'(mem[10'h50]), 32'h50);
        checkOutput("rstA_no_rsp", 32'(bus.rsp_valid), 32'd0);

        // Reset while a halfword store is in WRITE.
        startRequest(1'b1, 2'b01, 1'b0, 32'h60, 32'h0000ABCD);
        @(negedge clk);
        checkOutput("rstB_write_we", 32'(bus.mem_write_en), 32'd1);
        checkOutput("rstB_write_data", bus.mem_write_data, 32'h6362ABCD);
        checkOutput("rstB_write_addr", bus.mem_address, 32'h60);
        base = wr_pulses;
        reset = 1'b1;
        #1;
        checkOutput("rstB_we", 32'(bus.mem_write_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstB_no_write", 32'(wr_pulses - base), 32'd0);
        checkOutput("rstB_mem60", 32'(mem[10'h60]), 32'h60);
        checkOutput("rstB_no_rsp", 32'(bus.rsp_valid), 32'd0);

        applyStimulus(vectors[4], 99);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
